// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: execute-stage request/response handshake plus the datamem port of the load/store controller.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_write_en;
    logic [2:0]  mem_func3;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_en, mem_func3, mem_data_in
    );
    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_en, mem_func3, mem_data_in
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time load/store controller in front of datamem; misaligned
// halfword/word accesses are split into byte accesses and reassembled.
module lsu_ctrl #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SINGLE, SPLIT, DONE} state_t;
    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, asm_q, asm_d, asm_nx;
    logic [1:0]  k_q, k_d;
    logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_address_q, mem_address_d, mem_data_in_q, mem_data_in_d;
    logic        mem_write_en_q, mem_write_en_d;
    logic [2:0]  mem_func3_q, mem_func3_d;
    logic        illegal, misaligned;

    assign illegal = (bus.req_func3[1:0] == 2'b11) || (bus.req_func3[2] && (bus.req_func3[1] || bus.req_we));
    assign misaligned = (bus.req_func3[1:0] == 2'b01 && bus.req_addr[0]) ||
                        (bus.req_func3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        f3_d           = f3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        k_d            = k_q;
        asm_d          = asm_q;
        resp_valid_d   = 1'b0;
        resp_err_d     = resp_err_q;
        resp_rdata_d   = resp_rdata_q;
        mem_address_d  = '0;
        mem_write_en_d = 1'b0;
        mem_func3_d    = 3'b010;
        mem_data_in_d  = '0;
        asm_nx         = asm_q;
        asm_nx[{k_q, 3'b000} +: 8] = bus.mem_data_out[7:0];
        case (state_q)
            IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                f3_d    = bus.req_func3;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                k_d     = '0;
                asm_d   = '0;
                if (illegal || (misaligned && !ALLOW_MISALIGNED)) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else if (misaligned) begin
                    state_d        = SPLIT;
                    mem_address_d  = bus.req_addr;
                    mem_write_en_d = bus.req_we;
                    mem_func3_d    = bus.req_we ? 3'b000 : 3'b100;
                    mem_data_in_d  = {24'b0, bus.req_wdata[7:0]};
                end else begin
                    state_d        = SINGLE;
                    mem_address_d  = bus.req_addr;
                    mem_write_en_d = bus.req_we;
                    mem_func3_d    = bus.req_func3;
                    mem_data_in_d  = bus.req_wdata;
                end
            end
            SINGLE: begin
                state_d      = DONE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? '0 : bus.mem_data_out;
            end
            SPLIT: if (k_q == (f3_q[1] ? 2'd3 : 2'd1)) begin
                state_d      = DONE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? '0 : (f3_q == 3'b010) ? asm_nx :
                               {(f3_q == 3'b101) ? 16'h0 : {16{asm_nx[15]}}, asm_nx[15:0]};
            end else begin
                k_d            = k_q + 2'd1;
                asm_d          = asm_nx;
                mem_address_d  = addr_q + {30'b0, k_d};
                mem_write_en_d = we_q;
                mem_func3_d    = we_q ? 3'b000 : 3'b100;
                mem_data_in_d  = {24'b0, wdata_q[{k_d, 3'b000} +: 8]};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            f3_q           <= 3'b010;
            addr_q         <= '0;
            wdata_q        <= '0;
            k_q            <= '0;
            asm_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_rdata_q   <= '0;
            mem_address_q  <= '0;
            mem_write_en_q <= 1'b0;
            mem_func3_q    <= 3'b010;
            mem_data_in_q  <= '0;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            f3_q           <= f3_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            k_q            <= k_d;
            asm_q          <= asm_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_rdata_q   <= resp_rdata_d;
            mem_address_q  <= mem_address_d;
            mem_write_en_q <= mem_write_en_d;
            mem_func3_q    <= mem_func3_d;
            mem_data_in_q  <= mem_data_in_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_write_en = mem_write_en_q;
    assign bus.mem_func3    = mem_func3_q;
    assign bus.mem_data_in  = mem_data_in_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench; requests push expected responses and memory accesses,
// a negedge monitor pops and compares them against a behavioural datamem.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_ctrl_if bus ();
    lsu_ctrl_if busz ();
    lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) dutz (.clk(clk), .rst(rst), .bus(busz));

    typedef struct { logic [31:0] rdata; logic err; int unsigned lat; int unsigned t; } resp_t;
    typedef struct { logic [31:0] a; logic we; logic [2:0] f3; logic [31:0] d; } acc_t;
    resp_t rq[$];
    acc_t  aq[$];
    resp_t e;
    acc_t  x;
    int unsigned cyc = 0;
    int nchk = 0;
    int nerr = 0;
    bit mon_on = 1'b0;
    int unsigned t1, t2;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  mem [0:255];
    logic [7:0]  ma, b0, b1, b2, b3;
    logic [31:0] rd;
    always_comb begin
        ma = bus.mem_address[7:0];
        b0 = mem[ma];
        b1 = mem[ma + 8'd1];
        b2 = mem[ma + 8'd2];
        b3 = mem[ma + 8'd3];
        case (bus.mem_func3)
            3'b000:  rd = {{24{b0[7]}}, b0};
            3'b001:  rd = {{16{b1[7]}}, b1, b0};
            3'b100:  rd = {24'b0, b0};
            3'b101:  rd = {16'b0, b1, b0};
            default: rd = {b3, b2, b1, b0};
        endcase
    end
    assign bus.mem_data_out  = rd;
    assign busz.mem_data_out = 32'hDEADBEEF;

    // datamem writes on the edge regardless of rst, like the real memory
    always @(posedge clk) begin
        if (cyc < 2) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_address[7:0]] <= bus.mem_data_in[7:0];
            if (bus.mem_func3 != 3'b000) mem[bus.mem_address[7:0] + 8'd1] <= bus.mem_data_in[15:8];
            if (bus.mem_func3 == 3'b010) begin
                mem[bus.mem_address[7:0] + 8'd2] <= bus.mem_data_in[23:16];
                mem[bus.mem_address[7:0] + 8'd3] <= bus.mem_data_in[31:24];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (mon_on) begin
        if (bus.resp_valid) begin
            if (rq.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
                e = rq.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
                chk("resp_latency", cyc - e.t, e.lat);
                chk("done_write_en", {31'b0, bus.mem_write_en}, 0);
            end
        end else if (!bus.req_ready) begin
            if (aq.size() == 0) chk("unexpected_access", 1, 0);
            else begin
                x = aq.pop_front();
                chk("acc_addr", bus.mem_address, x.a);
                chk("acc_we_f3", {28'b0, bus.mem_write_en, bus.mem_func3}, {28'b0, x.we, x.f3});
                chk("acc_din", bus.mem_data_in, x.d);
            end
        end else begin
            chk("idle_mem", {bus.mem_address[27:0], bus.mem_write_en, bus.mem_func3} | {28'b0, 4'b0},
                {28'b0, 1'b0, 3'b010});
            chk("idle_din", bus.mem_data_in, 0);
        end
    end

    // n: 0 = rejected, 1 = aligned single access, 2/4 = split into n byte accesses
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int n);
        resp_t r;
        acc_t  c;
        logic [31:0] sh;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_func3 = f3;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        if (!bus.req_ready) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        r.rdata = exp_rd;
        r.err   = exp_err;
        r.lat   = (n == 0) ? 1 : n + 1;
        r.t     = cyc;
        rq.push_back(r);
        if (n == 1) begin
            c.a = a; c.we = we; c.f3 = f3; c.d = wd;
            aq.push_back(c);
        end else begin
            for (int i = 0; i < n; i++) begin
                sh   = wd >> (8 * i);
                c.a  = a + i;
                c.we = we;
                c.f3 = we ? 3'b000 : 3'b100;
                c.d  = {24'b0, sh[7:0]};
                aq.push_back(c);
            end
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (rq.size() != 0 || aq.size() != 0); i++) @(negedge clk);
        chk("drain", rq.size() + aq.size(), 0);
    endtask

    task automatic zreq(input logic [2:0] f3, input logic [31:0] a);
        @(negedge clk);
        busz.req_valid = 1'b1;
        busz.req_func3 = f3;
        busz.req_addr  = a;
        @(posedge clk);
        #1 busz.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_func3 = 3'b000;
        bus.req_addr  = '0;    bus.req_wdata = '0;
        busz.req_valid = 1'b0; busz.req_we = 1'b0; busz.req_func3 = 3'b000;
        busz.req_addr  = '0;   busz.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.req_ready}, 1);
        chk("rst_resp", {bus.resp_rdata[29:0], bus.resp_valid, bus.resp_err}, 0);
        chk("rst_mem", {bus.mem_address[27:0], bus.mem_write_en, bus.mem_func3}, {28'b0, 1'b0, 3'b010});
        chk("rst_din", bus.mem_data_in, 0);
        rst = 1'b0;
        mon_on = 1'b1;

        issue(1, 3'b010, 32'h4, 32'hAABBCCDD, 32'h0, 0, 1);
        t1 = cyc;
        issue(0, 3'b010, 32'h4, 32'h0, 32'hAABBCCDD, 0, 1);
        t2 = cyc;
        chk("throughput", t2 - t1, 3);
        issue(1, 3'b000, 32'h5, 32'h000000EE, 32'h0, 0, 1);
        issue(0, 3'b000, 32'h5, 32'h0, 32'hFFFFFFEE, 0, 1);
        issue(0, 3'b100, 32'h5, 32'h0, 32'h000000EE, 0, 1);
        issue(1, 3'b010, 32'h4, 32'hAABBCCDD, 32'h0, 0, 1);
        issue(1, 3'b010, 32'h8, 32'h11223344, 32'h0, 0, 1);
        issue(0, 3'b010, 32'h6, 32'h0, 32'h3344AABB, 0, 4);
        issue(0, 3'b001, 32'h5, 32'h0, 32'hFFFFBBCC, 0, 2);
        issue(0, 3'b101, 32'h7, 32'h0, 32'h000044AA, 0, 2);
        issue(1, 3'b001, 32'h7, 32'h00005678, 32'h0, 0, 2);
        issue(0, 3'b010, 32'h4, 32'h0, 32'h78BBCCDD, 0, 1);
        issue(0, 3'b010, 32'h8, 32'h0, 32'h11223356, 0, 1);
        issue(0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 0);
        issue(1, 3'b100, 32'h4, 32'h000000FF, 32'h0, 1, 0);
        issue(0, 3'b111, 32'h0, 32'h0, 32'h0, 1, 0);
        issue(0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 2);
        issue(0, 3'b010, 32'h8, 32'h0, 32'h11223356, 0, 1);
        drain();

        // reset sampled at the edge closing byte 1: bytes 0 and 1 land, nothing else
        issue(1, 3'b010, 32'h5, 32'h11223344, 32'h0, 0, 4);
        @(negedge clk);
        chk("rdata_hold", bus.resp_rdata, 32'h11223356);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_ready", {31'b0, bus.req_ready}, 1);
        chk("post_rst_resp", {bus.resp_rdata[29:0], bus.resp_valid, bus.resp_err}, 0);
        chk("post_rst_mem", {bus.mem_address[27:0], bus.mem_write_en, bus.mem_func3}, {28'b0, 1'b0, 3'b010});
        repeat (4) @(negedge clk);
        chk("rst_no_resp", rq.size(), 1);
        chk("rst_dropped_bytes", aq.size(), 2);
        rq.delete();
        aq.delete();
        issue(0, 3'b010, 32'h4, 32'h0, 32'h783344DD, 0, 1);
        issue(0, 3'b010, 32'h8, 32'h0, 32'h11223356, 0, 1);
        drain();

        zreq(3'b010, 32'h6);
        @(negedge clk);
        chk("z_lw6_valid_err", {30'b0, busz.resp_valid, busz.resp_err}, 3);
        chk("z_lw6_rdata", busz.resp_rdata, 0);
        chk("z_lw6_no_access", {busz.mem_address[27:0], busz.mem_write_en, busz.mem_func3}, {28'b0, 1'b0, 3'b010});
        @(negedge clk);
        chk("z_err_hold", {30'b0, busz.req_ready, busz.resp_err}, 3);
        zreq(3'b001, 32'h5);
        @(negedge clk);
        chk("z_lh5_valid_err", {30'b0, busz.resp_valid, busz.resp_err}, 3);
        zreq(3'b010, 32'h4);
        @(negedge clk);
        chk("z_lw4_access", {busz.mem_address[27:0], busz.mem_write_en, busz.mem_func3}, {28'h4, 1'b0, 3'b010});
        @(negedge clk);
        chk("z_lw4_valid_err", {30'b0, busz.resp_valid, busz.resp_err}, 2);
        chk("z_lw4_rdata", busz.resp_rdata, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
